uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Serial receive front end of the MCU: it consumes the `serial_in` line before any byte reaches the processor.
- Internal blocks: free-running baud-tick generator, 16x-oversampled 8N1 receiver FSM, and a small first-word-fall-through FIFO.
- The processor's load/IO path drains the FIFO.
- Line timing: 50 MHz clock, DVSR=26, one bit = 16 ticks = 416 clocks = 8320 ns.

Parameters:
- DVSR, 26: clocks per oversample tick; tick counter counts 0..DVSR-1.
- DATA_BITS, 8: data bits per frame, sent LSB first.
- SB_TICK, 16: ticks spanned by the stop bit.
- ADDR_W, 2: FIFO address width; depth = 2**ADDR_W = 4.

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- serial_in, input, 1: asynchronous UART line; idle high.
- rd_en, input, 1: pop FIFO head this cycle.
- err_clr, input, 1: clear the sticky frame_err and overrun flags.
- rd_data, output, DATA_BITS: FIFO head; valid when empty=0.
- empty, output, 1: FIFO holds no bytes.
- full, output, 1: FIFO holds 2**ADDR_W bytes.
- count, output, ADDR_W+1: number of bytes held.
- rx_done_tick, output, 1: one-clock pulse when a well-framed byte is completed.
- frame_err, output, 1: sticky; a stop bit was sampled low.
- overrun, output, 1: sticky; a byte was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - FSM=IDLE; tick counter, s_cnt, n and shift register = 0.
  - Both synchronizer flops = 1.
  - FIFO pointers = 0, so empty=1, full=0, count=0, rd_data=0.
  - rx_done_tick=0, frame_err=0, overrun=0.
- Reset mid-frame aborts the frame: no partial byte is pushed and FIFO contents are discarded.
- Synchronizer: serial_in passes through 2 flops to give rx_s. All FSM decisions use rx_s, so the line has 2 clocks of latency into the FSM.
- Tick generator:
  - Counts 0..DVSR-1 and wraps.
  - s_tick=1 for exactly one clock when count==DVSR-1.
  - Free-running; never resynchronised to frames.
- FSM states and transitions (s_cnt counts ticks, n counts bits):
  - IDLE: rx_s==0 -> START with s_cnt=0.
  - START: on s_tick, if s_cnt==7 (mid start bit): rx_s==0 -> DATA with s_cnt=0, n=0; rx_s==1 -> IDLE (glitch rejected, no flag set). Otherwise s_cnt++.
  - DATA: on s_tick, if s_cnt==15: shift rx_s into the MSB of the shift register (LSB-first assembly), s_cnt=0; n==DATA_BITS-1 -> STOP, else n++. Otherwise s_cnt++.
  - STOP: on s_tick, if s_cnt==SB_TICK-1 (mid stop bit): rx_s==1 -> push the byte and pulse rx_done_tick; rx_s==0 -> set frame_err and discard the byte. Both cases -> IDLE. Otherwise s_cnt++.
- Returning to IDLE mid stop bit lets a back-to-back start bit be detected with no lost time.
- Push timing:
  - The write occurs on the same edge that leaves STOP.
  - empty falls and count increments after that edge.
  - rd_data shows the head with 0 cycles additional latency (first-word fall-through).
- FIFO boundaries:
  - rd_en while empty: ignored; pointers unchanged.
  - Push while full and no pop: byte dropped, overrun=1, rx_done_tick still pulses.
  - Push and pop on the same edge while full: both happen; count stays 2**ADDR_W; overrun is not set.
  - Push and pop on the same edge while empty: push only; rd_en is ignored.
  - Pointers wrap modulo 2**ADDR_W.
  - full = (count == 2**ADDR_W); empty = (count == 0).
- Error flags:
  - err_clr=1 clears frame_err and overrun on the next edge.
  - If a set event coincides with err_clr, the set wins.

Test Plan:
1. Release reset at 40 ns with serial_in=1, then send 0x05, 0x0A, 0x0C back to back at 8320 ns/bit.
   - Three rx_done_tick pulses.
   - count goes 1, 2, 3.
   - rd_data=0x05 with empty=0, and no error flags.
2. After scenario 1, pulse rd_en three times.
   - rd_data reads 0x05, then 0x0A, then 0x0C.
   - empty=1 after the third pop.
   - A fourth rd_en leaves count=0.
3. Hold serial_in low for 3 ticks (~1600 ns), then high.
   - FSM returns to IDLE after the mid-start sample.
   - No push, no flags.
4. Send 0xA5 with the stop bit driven 0.
   - frame_err=1, count unchanged, no rx_done_tick.
   - err_clr pulse -> frame_err=0.
5. Send 5 bytes 0x11..0x15 without reading.
   - full=1 after 0x14.
   - 0x15 is dropped and overrun=1.
   - Drain order is 0x11, 0x12, 0x13, 0x14.
6. Assert reset=0 midway through the data bits of 0x3C, then release it and send 0x5A.
   - All outputs return to reset values immediately on reset.
   - Only 0x5A is received afterwards.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled 8N1 UART receiver feeding a small
// first-word-fall-through FIFO.
//   clock        - system clock, rising edge
//   reset        - asynchronous active-low reset
//   serial_in    - asynchronous UART line, idle high
//   rd_en        - pop the FIFO head this cycle (ignored when empty)
//   err_clr      - clear sticky frame_err / overrun
//   rd_data      - FIFO head, valid when empty=0
//   empty/full   - FIFO occupancy flags
//   count        - number of bytes held
//   rx_done_tick - one-clock pulse per well-framed byte
//   frame_err    - sticky, stop bit sampled low
//   overrun      - sticky, byte dropped because FIFO was full
module uart_rx_fifo #(
    parameter int unsigned DVSR      = 26,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned SB_TICK   = 16,
    parameter int unsigned ADDR_W    = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 serial_in,
    input  logic                 rd_en,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 empty,
    output logic                 full,
    output logic [ADDR_W:0]      count,
    output logic                 rx_done_tick,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned TICK_W = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int unsigned SCNT_W = $clog2(SB_TICK) > 4 ? $clog2(SB_TICK) : 4;
    localparam int unsigned N_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Two-flop synchronizer, reset to the idle-high line level
    logic sync1_q, rx_s;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            rx_s    <= sync1_q;
        end
    end

    // Free-running oversample tick generator
    logic [TICK_W-1:0] tick_q;
    logic              s_tick;

    assign s_tick = (tick_q == TICK_W'(DVSR - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_q <= '0;
        end else if (s_tick) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + TICK_W'(1);
        end
    end

    // Receiver FSM
    state_t              state_q, state_d;
    logic [SCNT_W-1:0]   s_cnt_q, s_cnt_d;
    logic [N_W-1:0]      n_q, n_d;
    logic [DATA_BITS-1:0] b_q, b_d;
    logic                push_c;
    logic                ferr_set_c;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_q     <= n_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!rx_s) state_d = START;
            end
            START: begin
                if (s_tick && s_cnt_q == SCNT_W'(7)) state_d = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (s_tick && s_cnt_q == SCNT_W'(15) && n_q == N_W'(DATA_BITS - 1))
                    state_d = STOP;
            end
            STOP: begin
                if (s_tick && s_cnt_q == SCNT_W'(SB_TICK - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters, shift register and frame result strobes
    always_comb begin
        s_cnt_d    = s_cnt_q;
        n_d        = n_q;
        b_d        = b_q;
        push_c     = 1'b0;
        ferr_set_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) s_cnt_d = '0;
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_q == SCNT_W'(7)) begin
                        if (!rx_s) begin
                            s_cnt_d = '0;
                            n_d     = '0;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SCNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == SCNT_W'(15)) begin
                        // LSB arrives first, so shift in from the top
                        b_d     = {rx_s, b_q[DATA_BITS-1:1]};
                        s_cnt_d = '0;
                        if (n_q != N_W'(DATA_BITS - 1)) n_d = n_q + N_W'(1);
                    end else begin
                        s_cnt_d = s_cnt_q + SCNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == SCNT_W'(SB_TICK - 1)) begin
                        if (rx_s) push_c     = 1'b1;
                        else      ferr_set_c = 1'b1;
                    end else begin
                        s_cnt_d = s_cnt_q + SCNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // FIFO
    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_d;
    logic                 pop_ok;
    logic                 push_ok;
    logic                 ovr_set;

    assign pop_ok  = rd_en && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge
    assign push_ok = push_c && (!full || pop_ok);
    assign ovr_set = push_c && full && !pop_ok;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count;
        if (push_ok && !pop_ok)      count_d = count + CNT_W'(1);
        else if (pop_ok && !push_ok) count_d = count - CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= b_q;
                wr_ptr_q        <= wr_ptr_q + ADDR_W'(1);
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            count <= count_d;
            empty <= (count_d == '0);
            full  <= (count_d == CNT_W'(DEPTH));
        end
    end

    // Done pulse and sticky flags; a set event beats a simultaneous clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            rx_done_tick <= push_c;
            if (ferr_set_c)   frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
            if (ovr_set)      overrun   <= 1'b1;
            else if (err_clr) overrun   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: frame-level reference model plus directed scenarios.
module tb_uart_rx_fifo;

    localparam int DVSR  = 26;
    localparam int DEPTH = 4;
    localparam int BIT_CLKS = 416;

    logic       clk;
    logic       rst_n;
    logic       serial_in;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       rx_done_tick;
    logic       frame_err;
    logic       overrun;

    uart_rx_fifo #(
        .DVSR(26), .DATA_BITS(8), .SB_TICK(16), .ADDR_W(2)
    ) dut (
        .clock        (clk),
        .reset        (rst_n),
        .serial_in    (serial_in),
        .rd_en        (rd_en),
        .err_clr      (err_clr),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    endtask

    // Reference model. The line is seen two edges late; a frame is timed as a
    // number of oversample ticks after the falling edge is first noticed:
    // start verified at tick 8, data bit k at tick 24+16k, stop at tick 152.
    logic [7:0] mq[$];
    bit         m_busy, m_done, m_ferr, m_ovr;
    int         m_ticks, tph;
    logic [7:0] m_byte;
    logic       h1, h2;

    always @(posedge clk or negedge rst_n) begin
        logic rx, stk, push, fe_set, ov_set, pop;
        if (!rst_n) begin
            m_busy = 0; m_ticks = 0; m_byte = '0; h1 = 1; h2 = 1; tph = 0;
            mq.delete(); m_done = 0; m_ferr = 0; m_ovr = 0;
        end else begin
            rx = h2;
            stk = (tph == DVSR - 1);
            push = 0; fe_set = 0; ov_set = 0;
            if (!m_busy) begin
                if (!rx) begin m_busy = 1; m_ticks = 0; end
            end else if (stk) begin
                m_ticks++;
                if (m_ticks == 8) begin
                    if (rx) m_busy = 0;
                end else if (m_ticks >= 24 && m_ticks <= 136 && (m_ticks - 24) % 16 == 0) begin
                    m_byte[(m_ticks - 24) / 16] = rx;
                end else if (m_ticks == 152) begin
                    m_busy = 0;
                    if (rx) push = 1; else fe_set = 1;
                end
            end
            pop = rd_en && (mq.size() > 0);
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(m_byte);
                else ov_set = 1;
            end
            m_done = push;
            if (fe_set) m_ferr = 1; else if (err_clr) m_ferr = 0;
            if (ov_set) m_ovr = 1;  else if (err_clr) m_ovr = 0;
            h2 = h1;
            h1 = serial_in;
            tph = (tph + 1) % DVSR;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("count", int'(count), mq.size());
        chk("empty", int'(empty), int'(mq.size() == 0));
        chk("full", int'(full), int'(mq.size() == DEPTH));
        if (mq.size() > 0) chk("rd_data", int'(rd_data), int'(mq[0]));
        chk("rx_done_tick", int'(rx_done_tick), int'(m_done));
        chk("frame_err", int'(frame_err), int'(m_ferr));
        chk("overrun", int'(overrun), int'(m_ovr));
        if (rx_done_tick) done_cnt++;
    end

    // Called at a falling clock edge; leaves the line high afterwards
    task automatic send_byte(input logic [7:0] b, input logic stop_v, input int stop_len);
        serial_in = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        serial_in = stop_v;
        repeat (stop_len) @(negedge clk);
        serial_in = 1'b1;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_rd_data"}, int'(rd_data), 0);
        chk({tag, "_done"}, int'(rx_done_tick), 0);
        chk({tag, "_ferr"}, int'(frame_err), 0);
        chk({tag, "_ovr"}, int'(overrun), 0);
    endtask

    initial begin
        logic [7:0] s1 [3];
        logic [7:0] b3c;
        s1[0] = 8'h05; s1[1] = 8'h0A; s1[2] = 8'h0C;
        b3c = 8'h3C;
        rst_n = 1'b1; serial_in = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        #1 rst_n = 1'b0;
        #19 chk_reset_vals("reset");
        #20 rst_n = 1'b1;
        @(negedge clk);

        // Three back-to-back frames
        for (int i = 0; i < 3; i++) begin
            send_byte(s1[i], 1'b1, BIT_CLKS);
            chk("s1_count", int'(count), i + 1);
        end
        repeat (20) @(negedge clk);
        chk("s1_pulses", done_cnt, 3);
        chk("s1_head", int'(rd_data), 8'h05);
        chk("s1_empty", int'(empty), 0);
        chk("s1_ferr", int'(frame_err), 0);
        chk("s1_ovr", int'(overrun), 0);

        // Drain in order, then pop while empty
        for (int i = 0; i < 3; i++) begin
            chk("s2_head", int'(rd_data), int'(s1[i]));
            pop_one();
        end
        chk("s2_empty", int'(empty), 1);
        pop_one();
        chk("s2_count", int'(count), 0);

        // Start-bit glitch of three ticks
        serial_in = 1'b0;
        repeat (78) @(negedge clk);
        serial_in = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        chk("s3_count", int'(count), 0);
        chk("s3_ferr", int'(frame_err), 0);
        chk("s3_pulses", done_cnt, 3);

        // Low stop bit, held low just past its centre so the line recovers cleanly
        send_byte(8'hA5, 1'b0, 260);
        repeat (2 * BIT_CLKS) @(negedge clk);
        chk("s4_ferr", int'(frame_err), 1);
        chk("s4_count", int'(count), 0);
        chk("s4_pulses", done_cnt, 3);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("s4_ferr_clr", int'(frame_err), 0);

        // Fill to full, then overrun
        for (int i = 0; i < 4; i++) send_byte(8'(8'h11 + i), 1'b1, BIT_CLKS);
        repeat (20) @(negedge clk);
        chk("s5_full", int'(full), 1);
        chk("s5_count", int'(count), 4);
        chk("s5_ovr_pre", int'(overrun), 0);
        send_byte(8'h15, 1'b1, BIT_CLKS);
        repeat (20) @(negedge clk);
        chk("s5_ovr", int'(overrun), 1);
        chk("s5_full2", int'(full), 1);
        chk("s5_pulses", done_cnt, 8);
        for (int i = 0; i < 4; i++) begin
            chk("s5_drain", int'(rd_data), 8'h11 + i);
            pop_one();
        end
        chk("s5_empty", int'(empty), 1);

        // Reset in the middle of the data bits of 0x3C
        serial_in = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            serial_in = b3c[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        serial_in = b3c[3];
        repeat (200) @(negedge clk);
        chk("s6_ovr_before", int'(overrun), 1);
        #3 rst_n = 1'b0;
        #1 chk_reset_vals("s6_reset");
        serial_in = 1'b1;
        repeat (50) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        send_byte(8'h5A, 1'b1, BIT_CLKS);
        repeat (20) @(negedge clk);
        chk("s6_count", int'(count), 1);
        chk("s6_head", int'(rd_data), 8'h5A);
        chk("s6_ferr", int'(frame_err), 0);
        chk("s6_ovr", int'(overrun), 0);
        chk("s6_pulses", done_cnt, 9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
